crc_frame_packer: RTL and testbench
===================================

CRC_FRAME_PACKER -- requirements
Module: crc_frame_packer

Interface
REQ-001 SHALL have parameters: DEPTH, 16, payload buffer bytes (power of 2, 2..256); TERM, 8'h0A, frame terminator byte.
REQ-002 SHALL have ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  8  byte from UART receiver.
- in_valid  in  1  one-cycle pulse; in_data valid this cycle.
- tx_data  out  8  byte to interfpga sender.
- tx_send  out  1  one-cycle send request.
- tx_busy  in  1  sender busy level.
- o_collecting  out  1  high in COLLECT state.
- o_crc8  out  8  running CRC of the current frame.
- o_drop_count  out  8  saturating count of rejected input bytes.

Function
REQ-003 SHALL implement states COLLECT, ISSUE, WAIT_HI, WAIT_LO.
REQ-004 In COLLECT, each in_valid SHALL write in_data to buffer[count], increment count, and update the CRC in the same cycle.
REQ-005 CRC SHALL use poly x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR, one byte per clock.
REQ-006 An accepted byte equal to TERM, or an accepted byte that makes count==DEPTH, SHALL end the frame.
- TERM is stored and sent as payload.
- The next state is ISSUE with idx=0 and sending_crc=0.
REQ-007 In ISSUE, tx_send SHALL be 1 for exactly one cycle.
- tx_data = buffer[idx], or the final CRC when sending_crc=1.
- Next state is WAIT_HI.
- Latency: the frame-ending byte is accepted at cycle N; tx_send is high at N+1.
REQ-008 In WAIT_HI, the block SHALL wait for tx_busy==1, then go to WAIT_LO.
REQ-009 In WAIT_LO, on tx_busy==0 the block SHALL:
- if idx<count-1: increment idx and go to ISSUE;
- else if sending_crc=0: set sending_crc=1 and go to ISSUE;
- else: clear count, CRC, idx and sending_crc, and go to COLLECT.
REQ-010 tx_data SHALL stay stable from ISSUE through the end of WAIT_LO; otherwise it holds its last value.
REQ-011 in_valid outside COLLECT SHALL be discarded and increment o_drop_count, saturating at 255.
REQ-012 in_valid on the same cycle as the frame-ending byte cannot occur (single source); any in_valid in the following cycle SHALL count as a drop.
REQ-013 o_crc8 SHALL show the running CRC and freeze at the final value from frame end until the return to COLLECT.
REQ-014 Each frame SHALL produce exactly count+1 tx_send pulses.
REQ-015 tx_busy already high on entry to WAIT_HI SHALL be accepted immediately; no timeout applies.

Reset
REQ-016 reset SHALL take priority over all inputs in the cycle it is sampled high.
REQ-017 reset SHALL set:
- state=COLLECT, count=0, idx=0, sending_crc=0;
- o_crc8=0, o_drop_count=0;
- tx_send=0, tx_data=0, o_collecting=1.
REQ-018 reset during ISSUE, WAIT_HI or WAIT_LO SHALL abandon the frame with no further tx_send.
- Buffer contents need not be cleared.

Structure
REQ-019 The shared package SHALL hold the state encoding (2-bit), CRC_POLY=8'h07, CRC_INIT=8'h00, and the default TERM.
REQ-020 The byte-wise CRC update SHALL be a combinational sub-module crc8_byte (inputs crc, data; output next crc) that the existing crc block can reuse.
REQ-021 The buffer SHALL be a register array or inferred RAM with synchronous write and combinational read.

Verification
REQ-022 Input 0x0A -> tx_send twice, tx_data 0x0A then 0x36; o_crc8=0x36.
REQ-023 Input 0x01, 0x0A -> tx_data 0x01, 0x0A, 0x23; exactly 3 tx_send pulses; back in COLLECT with o_crc8=0x00.
REQ-024 16 bytes of 0x00, no TERM -> 16 data bytes plus CRC 0x00 sent; the frame ends on byte 16.
REQ-025 Three in_valid pulses while in WAIT_HI/WAIT_LO -> o_drop_count=3; frame output unchanged.
REQ-026 reset asserted in WAIT_LO after byte 1 of a 3-byte frame -> no further tx_send; all outputs at reset values; a following frame 0x0A sends 0x0A, 0x36.
REQ-027 tx_busy held high 50 cycles per byte -> each next tx_send is exactly one cycle after tx_busy falls, and tx_data stays stable throughout.

Source files
------------

// File: rtl/crc_frame_packer_pkg.sv
// Shared definitions for the CRC frame packer: FSM encoding and CRC-8 constants.
package crc_frame_packer_pkg;

    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StIssue   = 2'd1,
        StWaitHi  = 2'd2,
        StWaitLo  = 2'd3
    } state_e;

    localparam logic [7:0] CRC_POLY     = 8'h07;
    localparam logic [7:0] CRC_INIT     = 8'h00;
    localparam logic [7:0] TERM_DEFAULT = 8'h0A;

endpackage

// File: rtl/crc8_byte.sv
// Combinational CRC-8 update for one byte, MSB first, no reflection.
module crc8_byte
    import crc_frame_packer_pkg::*;
(
    input  logic [7:0] crc_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    logic [7:0] c;

    always_comb begin
        c = crc_i ^ data_i;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
    end

    assign crc_o = c;

endmodule

// File: rtl/crc_frame_packer.sv
// Collects UART bytes into a frame, then streams payload plus CRC-8 to a
// busy-handshaked sender, one byte per send pulse.
module crc_frame_packer
    import crc_frame_packer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter logic [7:0]  TERM  = TERM_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_busy,
    output logic       o_collecting,
    output logic [7:0] o_crc8,
    output logic [7:0] o_drop_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    logic [7:0]    buf_q [DEPTH];
    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          sending_crc_q, sending_crc_d;
    logic [7:0]    crc_q, crc_d, crc_next;
    logic [7:0]    drop_q, drop_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          wr_en;
    logic [AW-1:0] idx_inc;
    logic [CW-1:0] idx_inc_ext;

    assign idx_inc     = idx_q + AW'(1);
    assign idx_inc_ext = {1'b0, idx_q} + CW'(1);

    crc8_byte u_crc8_byte (
        .crc_i  (crc_q),
        .data_i (in_data),
        .crc_o  (crc_next)
    );

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        idx_d         = idx_q;
        sending_crc_d = sending_crc_q;
        crc_d         = crc_q;
        drop_d        = drop_q;
        tx_data_d     = tx_data_q;
        wr_en         = 1'b0;

        if (in_valid && (state_q != StCollect) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        unique case (state_q)
            StCollect: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                    crc_d   = crc_next;
                    if ((in_data == TERM) || (count_d == DepthC)) begin
                        state_d       = StIssue;
                        idx_d         = '0;
                        sending_crc_d = 1'b0;
                        // Byte 0 may be landing in the buffer this very cycle.
                        tx_data_d     = (count_q == '0) ? in_data : buf_q[0];
                    end
                end
            end
            StIssue: begin
                state_d = StWaitHi;
            end
            StWaitHi: begin
                if (tx_busy) begin
                    state_d = StWaitLo;
                end
            end
            StWaitLo: begin
                if (!tx_busy) begin
                    if (idx_inc_ext < count_q) begin
                        idx_d     = idx_inc;
                        tx_data_d = buf_q[idx_inc];
                        state_d   = StIssue;
                    end else if (!sending_crc_q) begin
                        sending_crc_d = 1'b1;
                        tx_data_d     = crc_q;
                        state_d       = StIssue;
                    end else begin
                        count_d       = '0;
                        crc_d         = CRC_INIT;
                        idx_d         = '0;
                        sending_crc_d = 1'b0;
                        state_d       = StCollect;
                    end
                end
            end
            default: begin
                state_d = StCollect;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StCollect;
            count_q       <= '0;
            idx_q         <= '0;
            sending_crc_q <= 1'b0;
            crc_q         <= CRC_INIT;
            drop_q        <= 8'h00;
            tx_data_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            sending_crc_q <= sending_crc_d;
            crc_q         <= crc_d;
            drop_q        <= drop_d;
            tx_data_q     <= tx_data_d;
        end
    end

    // Payload storage is never reset; only count decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            buf_q[count_q[AW-1:0]] <= in_data;
        end
    end

    assign tx_send      = (state_q == StIssue);
    assign tx_data      = tx_data_q;
    assign o_collecting = (state_q == StCollect);
    assign o_crc8       = crc_q;
    assign o_drop_count = drop_q;

endmodule

// File: tb/tb_crc_frame_packer.sv
// Directed bench for crc_frame_packer with a queue-based frame model and a
// simple busy-handshake sender model.
module tb_crc_frame_packer;

    localparam int unsigned DEPTH = 16;
    localparam logic [7:0]  TERM  = 8'h0A;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;
    logic       o_collecting;
    logic [7:0] o_crc8;
    logic [7:0] o_drop_count;

    crc_frame_packer #(
        .DEPTH (DEPTH),
        .TERM  (TERM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .tx_data      (tx_data),
        .tx_send      (tx_send),
        .tx_busy      (tx_busy),
        .o_collecting (o_collecting),
        .o_crc8       (o_crc8),
        .o_drop_count (o_drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_crc = 8'h00;
    logic [7:0] held = 8'h00;
    bit         first_pending = 1'b0;
    int         last_in_cyc = 0;
    int         busy_fall_cyc = 0;
    int         drop_exp = 0;
    int         busy_delay = 1;
    int         busy_len = 2;
    int         pulses = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bit-serial polynomial division, MSB first.
    function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
        logic [7:0] r = 8'h00;
        logic       fb;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ msg[i][b];
                r  = {r[6:0], 1'b0};
                if (fb) r = r ^ 8'h07;
            end
        end
        return r;
    endfunction

    // Output checker: every send pulse must match the model queue and timing.
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_send) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    check("unexpected_tx_send", 1, 0);
                end else begin
                    check("tx_data", int'(tx_data), int'(exp_q.pop_front()));
                    check("o_crc8_frozen", int'(o_crc8), int'(exp_crc));
                    if (first_pending) begin
                        check("frame_end_to_send", cyc, last_in_cyc + 1);
                        first_pending = 1'b0;
                    end else begin
                        check("busy_fall_to_send", cyc, busy_fall_cyc + 1);
                    end
                end
                check("collecting_during_send", int'(o_collecting), 0);
                held = tx_data;
            end else begin
                check("tx_data_hold", int'(tx_data), int'(held));
            end
        end
    end

    // Sender model: busy rises busy_delay cycles after a send, lasts busy_len.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_send && !reset) begin
                repeat (busy_delay) @(negedge clk);
                tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                tx_busy = 1'b0;
                busy_fall_cyc = cyc;
            end
        end
    end

    task automatic send_frame(input logic [7:0] bytes[$]);
        logic [7:0] frame[$];
        bit ended = 1'b0;
        foreach (bytes[i]) begin
            @(negedge clk);
            in_data  = bytes[i];
            in_valid = 1'b1;
            if (!ended) begin
                frame.push_back(bytes[i]);
                last_in_cyc = cyc;
                if (bytes[i] == TERM || frame.size() == DEPTH) begin
                    ended   = 1'b1;
                    exp_crc = model_crc(frame);
                    exp_q   = frame;
                    exp_q.push_back(exp_crc);
                    first_pending = 1'b1;
                end
            end else if (drop_exp < 255) begin
                drop_exp++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (!(exp_q.size() == 0 && o_collecting === 1'b1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(n < limit), 1);
        check({name, "_crc_cleared"}, int'(o_crc8), 0);
        check({name, "_drops"}, int'(o_drop_count), drop_exp);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_tx_send"}, int'(tx_send), 0);
        check({name, "_tx_data"}, int'(tx_data), 0);
        check({name, "_collecting"}, int'(o_collecting), 1);
        check({name, "_crc"}, int'(o_crc8), 0);
        check({name, "_drops"}, int'(o_drop_count), 0);
    endtask

    initial begin
        logic [7:0] q[$];
        int p0;
        int n;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_values("reset");

        q = '{8'h0A};
        check("model_pin_0A", int'(model_crc(q)), 'h36);
        q = '{8'h01, 8'h0A};
        check("model_pin_01_0A", int'(model_crc(q)), 'h23);
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'h00);
        check("model_pin_zeros", int'(model_crc(q)), 'h00);

        // Single terminator byte.
        p0 = pulses;
        q = '{8'h0A};
        send_frame(q);
        check("crc_0A", int'(o_crc8), 'h36);
        wait_idle("frame_0A", 200);
        check("pulses_0A", pulses - p0, 2);

        // Two-byte frame.
        p0 = pulses;
        q = '{8'h01, 8'h0A};
        send_frame(q);
        check("crc_01_0A", int'(o_crc8), 'h23);
        wait_idle("frame_01_0A", 200);
        check("pulses_01_0A", pulses - p0, 3);

        // Buffer fills without a terminator.
        p0 = pulses;
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'h00);
        send_frame(q);
        check("crc_zeros", int'(o_crc8), 'h00);
        check("collecting_after_full", int'(o_collecting), 0);
        wait_idle("frame_full", 400);
        check("pulses_full", pulses - p0, 17);

        // Bytes arriving while the frame drains are dropped.
        busy_len = 8;
        p0 = pulses;
        q = '{8'h55, 8'h0A, 8'hAA, 8'hBB, 8'hCC};
        send_frame(q);
        wait_idle("frame_drops", 400);
        check("drop_count_3", int'(o_drop_count), 3);
        check("pulses_drops", pulses - p0, 3);

        // Busy already high when WAIT_HI is entered.
        busy_delay = 0;
        busy_len   = 3;
        p0 = pulses;
        q = '{8'hDE, 8'hAD, 8'h0A};
        send_frame(q);
        wait_idle("frame_busy_early", 400);
        check("pulses_busy_early", pulses - p0, 4);

        // Long busy periods.
        busy_delay = 1;
        busy_len   = 50;
        p0 = pulses;
        q = '{8'h12, 8'h34, 8'h0A};
        send_frame(q);
        wait_idle("frame_slow", 1000);
        check("pulses_slow", pulses - p0, 4);

        // Reset in the middle of draining a frame.
        busy_len = 10;
        q = '{8'h11, 8'h22, 8'h0A};
        send_frame(q);
        n = 0;
        while (!tx_send && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("first_send_before_reset", int'(n < 100), 1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        first_pending = 1'b0;
        held = 8'h00;
        drop_exp = 0;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("mid_frame_reset");
        repeat (30) @(negedge clk);
        check_reset_values("after_reset_quiet");

        busy_len = 2;
        p0 = pulses;
        q = '{8'h0A};
        send_frame(q);
        check("crc_after_reset", int'(o_crc8), 'h36);
        wait_idle("frame_after_reset", 200);
        check("pulses_after_reset", pulses - p0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
